// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified memory arbiter
package mem_arb_pkg;

    // Which port owns the read/write response arriving next cycle.
    typedef enum logic [1:0] {
        RESP_NONE    = 2'd0,
        RESP_INSTR   = 2'd1,
        RESP_DATA_RD = 2'd2,
        RESP_DATA_WR = 2'd3
    } resp_owner_t;

    // addi x0, x0, 0: what the fetch port shows before its first response.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int MAX_DATA_BURST_DEF = 4;

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - combinational data-priority grant with fetch fairness
//
// Ports:
//   instr_req_i  fetch request
//   data_req_i   data request
//   burst_cnt_i  consecutive data grants issued while fetch was waiting
//   instr_gnt_o  fetch granted this cycle
//   data_gnt_o   data granted this cycle
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_BURST = MAX_DATA_BURST_DEF
) (
    input  logic       instr_req_i,
    input  logic       data_req_i,
    input  logic [3:0] burst_cnt_i,
    output logic       instr_gnt_o,
    output logic       data_gnt_o
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_DATA_BURST);

    logic w_fetch_due;

    // Data wins unless fetch has already waited out a full burst.
    assign w_fetch_due = instr_req_i && (burst_cnt_i == MAX_CNT);
    assign data_gnt_o  = data_req_i && !w_fetch_due;
    assign instr_gnt_o = instr_req_i && !data_gnt_o;

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one synchronous-read RAM between fetch and data ports
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   instr_req_i/addr_i            fetch request (level, held until granted)
//   instr_gnt_o/rvalid_o/rdata_o  fetch grant, response strobe, held read data
//   instr_stall_o                 fetch requested but not granted
//   data_req_i/we_i/addr_i/wdata_i  data request (we == 0 means read)
//   data_gnt_o/rvalid_o/rdata_o   data grant, response strobe, held read data
//   data_stall_o                  data requested but not granted
//   mem_en_o/we_o/addr_o/wdata_o  RAM access of the granted port
//   mem_rdata_i                   RAM read data, one cycle after mem_en_o
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_BURST = MAX_DATA_BURST_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_stall_o,
    input  logic        data_req_i,
    input  logic [3:0]  data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_stall_o,
    output logic        mem_en_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_DATA_BURST);

    logic [3:0]  r_burst_cnt;
    resp_owner_t r_resp_owner;
    resp_owner_t w_resp_next;
    logic [31:0] r_instr_rdata;
    logic [31:0] r_data_rdata;
    logic        w_instr_gnt;
    logic        w_data_gnt;

    mem_arb_grant #(
        .MAX_DATA_BURST(MAX_DATA_BURST)
    ) u_grant (
        .instr_req_i (instr_req_i),
        .data_req_i  (data_req_i),
        .burst_cnt_i (r_burst_cnt),
        .instr_gnt_o (w_instr_gnt),
        .data_gnt_o  (w_data_gnt)
    );

    assign instr_gnt_o   = w_instr_gnt;
    assign data_gnt_o    = w_data_gnt;
    assign instr_stall_o = instr_req_i && !w_instr_gnt;
    assign data_stall_o  = data_req_i && !w_data_gnt;

    // Data port drives address/wdata whenever fetch is not granted, idle included.
    assign mem_en_o    = w_instr_gnt || w_data_gnt;
    assign mem_we_o    = w_data_gnt ? data_we_i : 4'b0000;
    assign mem_addr_o  = w_instr_gnt ? {instr_addr_i[31:2], 2'b00} : {data_addr_i[31:2], 2'b00};
    assign mem_wdata_o = data_wdata_i;

    always_comb begin
        w_resp_next = RESP_NONE;
        if (w_instr_gnt) begin
            w_resp_next = RESP_INSTR;
        end else if (w_data_gnt) begin
            w_resp_next = (data_we_i != 4'b0000) ? RESP_DATA_WR : RESP_DATA_RD;
        end
    end

    // Counts data grants that overtook a waiting fetch; any cycle without a
    // waiting fetch restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_cnt <= 4'd0;
        end else if (!instr_req_i || w_instr_gnt) begin
            r_burst_cnt <= 4'd0;
        end else if (w_data_gnt && (r_burst_cnt != MAX_CNT)) begin
            r_burst_cnt <= r_burst_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_owner <= RESP_NONE;
        end else begin
            r_resp_owner <= w_resp_next;
        end
    end

    // The RAM word is passed straight through in the response cycle and
    // latched so it stays visible until the port's next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_rdata <= NOP_INSTR;
            r_data_rdata  <= 32'd0;
        end else begin
            if (r_resp_owner == RESP_INSTR) begin
                r_instr_rdata <= mem_rdata_i;
            end
            if (r_resp_owner == RESP_DATA_RD) begin
                r_data_rdata <= mem_rdata_i;
            end
        end
    end

    assign instr_rvalid_o = (r_resp_owner == RESP_INSTR);
    assign data_rvalid_o  = (r_resp_owner == RESP_DATA_RD) || (r_resp_owner == RESP_DATA_WR);
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : r_instr_rdata;
    assign data_rdata_o   = (r_resp_owner == RESP_DATA_RD) ? mem_rdata_i : r_data_rdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed scoreboard bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

    localparam int MAXB = 4;

    typedef struct packed {
        logic        wr;
        logic [31:0] val;
    } dresp_t;

    logic        clk;
    logic        rst_n;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_stall_o;
    logic        data_req_i;
    logic [3:0]  data_we_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_stall_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    logic [31:0] ram     [0:255];
    logic [31:0] ref_mem [0:255];

    logic [31:0] iq[$];
    dresp_t      dq[$];
    logic        exp_irv;
    logic        exp_drv;
    logic [31:0] exp_ihold;
    logic [31:0] exp_dhold;
    int          m_cnt;
    int          n_checks;
    int          n_errors;

    unified_mem_arbiter #(
        .MAX_DATA_BURST(MAXB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_stall_o  (instr_stall_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_stall_o   (data_stall_o),
        .mem_en_o       (mem_en_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with one-cycle synchronous read and byte-lane writes.
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o == 4'b0000) begin
                mem_rdata_i <= ram[mem_addr_o[9:2]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we_o[b]) ram[mem_addr_o[9:2]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check responses owed from the previous cycle, drive the
    // new requests, check grants against the reference arbiter, then advance.
    task automatic step(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                        input logic [3:0] dwe, input logic [31:0] daddr, input logic [31:0] dwd);
        logic   gi;
        logic   gd;
        dresp_t r;
        chk("instr_rvalid", {31'd0, instr_rvalid_o}, {31'd0, exp_irv});
        chk("data_rvalid", {31'd0, data_rvalid_o}, {31'd0, exp_drv});
        if (exp_irv) begin
            if (iq.size() > 0) exp_ihold = iq.pop_front();
            else chk("instr_queue_empty", 32'd1, 32'd0);
        end
        if (exp_drv) begin
            if (dq.size() > 0) begin
                r = dq.pop_front();
                if (!r.wr) exp_dhold = r.val;
            end else chk("data_queue_empty", 32'd1, 32'd0);
        end
        chk("instr_rdata", instr_rdata_o, exp_ihold);
        chk("data_rdata", data_rdata_o, exp_dhold);

        instr_req_i  = ireq;
        instr_addr_i = iaddr;
        data_req_i   = dreq;
        data_we_i    = dwe;
        data_addr_i  = daddr;
        data_wdata_i = dwd;
        #1;
        gd = dreq && !(ireq && (m_cnt == MAXB));
        gi = ireq && !gd;
        chk("instr_gnt", {31'd0, instr_gnt_o}, {31'd0, gi});
        chk("data_gnt", {31'd0, data_gnt_o}, {31'd0, gd});
        chk("instr_stall", {31'd0, instr_stall_o}, {31'd0, ireq && !gi});
        chk("data_stall", {31'd0, data_stall_o}, {31'd0, dreq && !gd});
        chk("mem_en", {31'd0, mem_en_o}, {31'd0, gi || gd});
        chk("mem_we", {28'd0, mem_we_o}, {28'd0, (gd ? dwe : 4'b0000)});
        if (gi) begin
            chk("mem_addr_i", mem_addr_o, {iaddr[31:2], 2'b00});
            iq.push_back(ref_mem[iaddr[9:2]]);
        end
        if (gd) begin
            chk("mem_addr_d", mem_addr_o, {daddr[31:2], 2'b00});
            if (dwe == 4'b0000) begin
                dq.push_back({1'b0, ref_mem[daddr[9:2]]});
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (dwe[b]) ref_mem[daddr[9:2]][b*8 +: 8] = dwd[b*8 +: 8];
                end
                dq.push_back({1'b1, 32'd0});
            end
        end
        if (!ireq || gi) m_cnt = 0;
        else if (gd && m_cnt != MAXB) m_cnt++;
        exp_irv = gi;
        exp_drv = gd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 1'b0, 4'b0000, 32'd0, 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        m_cnt     = 0;
        exp_irv   = 1'b0;
        exp_drv   = 1'b0;
        exp_ihold = 32'h0000_0013;
        exp_dhold = 32'd0;
        for (int k = 0; k < 256; k++) begin
            ram[k]     = 32'hC0DE_0000 + 32'(k * 32'h0101);
            ref_mem[k] = 32'hC0DE_0000 + 32'(k * 32'h0101);
        end
        ram[64]     = 32'h1122_3344;
        ref_mem[64] = 32'h1122_3344;
        mem_rdata_i  = 32'd0;
        rst_n        = 1'b0;
        instr_req_i  = 1'b0;
        instr_addr_i = 32'd0;
        data_req_i   = 1'b0;
        data_we_i    = 4'b0000;
        data_addr_i  = 32'd0;
        data_wdata_i = 32'd0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state: no responses, NOP / zero held data, idle memory.
        idle();

        // Fetch stream of words 0, 1, 2 on back-to-back cycles.
        step(1'b1, 32'h0, 1'b0, 4'b0000, 32'd0, 32'd0);
        step(1'b1, 32'h4, 1'b0, 4'b0000, 32'd0, 32'd0);
        step(1'b1, 32'h8, 1'b0, 4'b0000, 32'd0, 32'd0);
        idle();

        // Partial write then read-back of the same word; low address bits ignored.
        step(1'b0, 32'd0, 1'b1, 4'b0011, 32'h100, 32'hAABB_CCDD);
        step(1'b0, 32'd0, 1'b1, 4'b0000, 32'h102, 32'd0);
        idle();
        chk("merged_word", exp_dhold, 32'h1122_CCDD);
        idle();

        // Both ports requesting continuously: D,D,D,D,I twice over.
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 32'(k * 4), 1'b1, 4'b0000, 32'(32'h200 + k * 4), 32'd0);
        end
        idle();

        // Long data-only run, then fetch joins and waits a bounded time.
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 32'd0, 1'b1, 4'b0000, 32'(32'h40 + k * 4), 32'd0);
        end
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 32'h30, 1'b1, 4'b0000, 32'(32'h80 + k * 4), 32'd0);
        end
        idle();

        // Reset right after a fetch grant: the response is dropped.
        step(1'b1, 32'h10, 1'b0, 4'b0000, 32'd0, 32'd0);
        instr_req_i = 1'b0;
        rst_n       = 1'b0;
        #1;
        chk("rst_instr_rvalid", {31'd0, instr_rvalid_o}, 32'd0);
        chk("rst_instr_rdata", instr_rdata_o, 32'h0000_0013);
        iq.delete();
        dq.delete();
        exp_irv   = 1'b0;
        exp_drv   = 1'b0;
        exp_ihold = 32'h0000_0013;
        exp_dhold = 32'd0;
        m_cnt     = 0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle();
        idle();

        // Activity after reset, then idle cycles holding the last data.
        step(1'b1, 32'h14, 1'b1, 4'b0000, 32'h104, 32'd0);
        step(1'b1, 32'h14, 1'b0, 4'b0000, 32'd0, 32'd0);
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
